hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline control unit sitting directly downstream of the operand-forwarding block. It consumes the forwarding block's per-stage "no forwardable data" stall requests, plus the EXA redirect and the MEMP data-memory handshake. From these it produces per-stage register enables, bubble injections and the fetch redirect for the 8-stage pipeline IF→IDC→IDR→EXB→EXA→MEMP→MEMR→WB. It also owns the post-redirect refill sequencing, a data-hazard watchdog and stall/flush performance counters.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles after a redirect during which IDC is fed bubbles (fetch refill latency); legal range 0..15.
MAX_DSTALL, 8, consecutive data-stall cycles that trip hazard_timeout; legal range 1..255.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
no_forwarding_data_IDR  in  1  IDC operand depends on an IDR producer
no_forwarding_data_EXB  in  1  IDC operand depends on an EXB producer
no_forwarding_data_MEMP  in  1  IDC operand depends on a load in MEMP
redirect_EXA  in  1  control-flow mispredict resolved in EXA
redirect_pc_EXA  in  64  correct target PC
dm_req_MEMP  in  1  MEMP has a data-memory access outstanding
dm_ack  in  1  data memory completes the access this cycle
stage_en  out  8  bit s=1: the register feeding stage s loads (bit 0 = PC/IF)
bubble  out  8  bit s=1: the register feeding stage s loads a NOP (valid=0); meaningful only when stage_en[s]=1
pc_redirect_valid  out  1  load pc_redirect into PC this cycle
pc_redirect  out  64  redirect target
hazard_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Interface: single clock clk; rst is asynchronous and active-high.
- Stage index: IF=0, IDC=1, IDR=2, EXB=3, EXA=4, MEMP=5, MEMR=6, WB=7.
- While rst=1:
  - stage_en=8'h00, bubble=8'hFF, pc_redirect_valid=0, pc_redirect=0.
  - state=RUN, all counters 0, hazard_timeout=0.
- Control outputs are combinational from the registered state and the current inputs; they take effect in the same cycle.
- Internal conditions:
  - mstall = dm_req_MEMP & ~dm_ack
  - dhaz = any no_forwarding_data_* flag
  - redir = redirect_EXA & ~mstall
- Priority: mstall > redir > dhaz > normal.
- Normal cycle: stage_en=8'hFF, bubble=0.
- mstall: stage_en[0..5]=0 (PC through MEMP frozen); stage_en[6]=1 with bubble[6]=1; stage_en[7]=1. A redirect held in frozen EXA is not acted on and does not count; it fires once mstall drops.
- redir:
  - stage_en=8'hFF; bubble[1..4]=1, flushing the IF, IDC, IDR and EXB instructions.
  - pc_redirect_valid=1, pc_redirect=redirect_pc_EXA.
  - flush_count increments.
  - Next state is REFILL with refill_cnt=REDIRECT_BUBBLES, or RUN if REDIRECT_BUBBLES=0.
- dhaz (state RUN, no mstall, no redir): stage_en[0]=stage_en[1]=0; stage_en[2..7]=1 with bubble[2]=1. The stall releases combinationally when the flags drop; the data stall has no latency of its own.
- FSM states:
  - RUN.
  - REFILL: bubble[1]=1 and dhaz is ignored, since IDC holds a bubble. refill_cnt decrements on every non-mstall cycle; the FSM moves to RUN in the cycle after it reaches 0. A redir in REFILL reloads refill_cnt. During mstall, refill_cnt holds.
- Watchdog:
  - dstall_cnt increments on each cycle where dhaz is acted on (RUN, no mstall, no redir) and clears on any other cycle.
  - When dstall_cnt reaches MAX_DSTALL, hazard_timeout is set and stays at 1 until rst.
  - dstall_cnt saturates and does not wrap.
- stall_cycles increments on each mstall cycle or acted-on dhaz cycle.
- Both performance counters saturate at all-ones.
- Reset mid-REFILL or mid-mstall discards all pending state; the pipeline resumes in RUN.

Decomposition:
- Package hazard_ctrl_pkg:
  - stage index constants (STG_IF..STG_WB)
  - NUM_STAGES=8
  - state enum {RUN, REFILL}
- One sub-module, sat_counter (parameterised width, inc, clr, async rst), used for stall_cycles, flush_count and dstall_cnt.

Test Plan:
- Reset: rst=1 mid-run → stage_en=00, bubble=FF, counters 0. Release with no inputs active → stage_en=FF, bubble=00.
- IDR hazard: no_forwarding_data_IDR=1 for 3 cycles → each cycle stage_en=FC, bubble=04; stall_cycles=3. Flag drops → stage_en=FF.
- Memory wait: dm_req_MEMP=1, dm_ack=0 for 4 cycles with redirect_EXA=1 and pc 0x8000_0100 → stage_en=C0, bubble=40, pc_redirect_valid=0. On the ack cycle, redirect fires once: bubble=1E, flush_count=1.
- Refill, REDIRECT_BUBBLES=2: redirect to 0x8000_0040 → pc_redirect_valid=1 for one cycle. The next 2 cycles have bubble[1]=1 with no_forwarding_data_EXB=1 ignored (stage_en=FF). The cycle after that is RUN.
- Back-to-back redirects in REFILL → refill_cnt reloads, flush_count=2, pc_redirect takes the second target.
- Watchdog, MAX_DSTALL=8: hold no_forwarding_data_MEMP=1 for 8 cycles → hazard_timeout=1 from the 8th cycle. It stays 1 after the flag clears; rst clears it.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared stage indices and FSM state type for hazard_ctrl
package hazard_ctrl_pkg;

    localparam int NUM_STAGES = 8;

    localparam int STG_IF   = 0;
    localparam int STG_IDC  = 1;
    localparam int STG_IDR  = 2;
    localparam int STG_EXB  = 3;
    localparam int STG_EXA  = 4;
    localparam int STG_MEMP = 5;
    localparam int STG_MEMR = 6;
    localparam int STG_WB   = 7;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (async active-high), inc (count up), clr (zero, wins over inc),
//        count (current value, holds at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/redirect control for the 8-stage pipeline
// Ports: clk, rst (async active-high);
//        no_forwarding_data_{IDR,EXB,MEMP} - data-hazard stall requests for IDC;
//        redirect_EXA / redirect_pc_EXA   - mispredict and correct target;
//        dm_req_MEMP / dm_ack              - data-memory handshake;
//        stage_en / bubble                 - per-stage load enable and NOP injection;
//        pc_redirect_valid / pc_redirect   - fetch redirect;
//        hazard_timeout                    - sticky data-stall watchdog;
//        stall_cycles / flush_count        - saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MAX_DSTALL       = 8,
    parameter int CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  no_forwarding_data_IDR,
    input  logic                  no_forwarding_data_EXB,
    input  logic                  no_forwarding_data_MEMP,
    input  logic                  redirect_EXA,
    input  logic [63:0]           redirect_pc_EXA,
    input  logic                  dm_req_MEMP,
    input  logic                  dm_ack,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  pc_redirect_valid,
    output logic [63:0]           pc_redirect,
    output logic                  hazard_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [3:0] REFILL_LOAD = 4'(REDIRECT_BUBBLES);
    localparam logic [7:0] DSTALL_LIM  = 8'(MAX_DSTALL - 1);

    state_t     state;
    logic [3:0] refill_cnt;
    logic [7:0] dstall_cnt;
    logic       timeout_q;

    logic mstall;
    logic dhaz;
    logic redir;
    logic dhaz_act;
    logic timeout_hit;

    assign mstall   = dm_req_MEMP & ~dm_ack;
    assign dhaz     = no_forwarding_data_IDR | no_forwarding_data_EXB | no_forwarding_data_MEMP;
    // A redirect sitting in a frozen EXA must wait until the memory stall clears.
    assign redir    = redirect_EXA & ~mstall;
    // IDC holds a bubble during REFILL, so its hazard flags are meaningless there.
    assign dhaz_act = dhaz & ~mstall & ~redir & (state == RUN);

    // Fires in the cycle that completes the MAX_DSTALL-th consecutive stall so the
    // flag is visible without waiting for the counter register to catch up.
    assign timeout_hit    = dhaz_act & (dstall_cnt >= DSTALL_LIM);
    assign hazard_timeout = timeout_q | timeout_hit;

    always_comb begin
        stage_en          = '1;
        bubble            = '0;
        pc_redirect_valid = 1'b0;
        pc_redirect       = '0;
        if (rst) begin
            stage_en = '0;
            bubble   = '1;
        end else if (mstall) begin
            // Freeze PC..MEMP; MEMR takes a NOP so WB can still drain.
            stage_en           = '0;
            stage_en[STG_MEMR] = 1'b1;
            stage_en[STG_WB]   = 1'b1;
            bubble[STG_MEMR]   = 1'b1;
        end else if (redir) begin
            bubble[STG_IDC]   = 1'b1;
            bubble[STG_IDR]   = 1'b1;
            bubble[STG_EXB]   = 1'b1;
            bubble[STG_EXA]   = 1'b1;
            pc_redirect_valid = 1'b1;
            pc_redirect       = redirect_pc_EXA;
        end else if (state == REFILL) begin
            bubble[STG_IDC] = 1'b1;
        end else if (dhaz) begin
            stage_en[STG_IF]  = 1'b0;
            stage_en[STG_IDC] = 1'b0;
            bubble[STG_IDR]   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            refill_cnt <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_q | timeout_hit;
            if (redir) begin
                refill_cnt <= REFILL_LOAD;
                state      <= (REDIRECT_BUBBLES == 0) ? RUN : REFILL;
            end else if ((state == REFILL) && !mstall) begin
                // Leave REFILL on the edge where the count reaches zero.
                if (refill_cnt <= 4'd1) begin
                    refill_cnt <= '0;
                    state      <= RUN;
                end else begin
                    refill_cnt <= refill_cnt - 4'd1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mstall | dhaz_act),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir),
        .clr   (1'b0),
        .count (flush_count)
    );

    sat_counter #(.W(8)) u_dstall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dhaz_act),
        .clr   (~dhaz_act),
        .count (dstall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idr, exb, memp, redirect, req, ack;
    logic [63:0] rpc;
    logic [7:0]  stage_en, bubble;
    logic        pcv, timeout;
    logic [63:0] pcr;
    logic [31:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REDIRECT_BUBBLES (2),
        .MAX_DSTALL       (8),
        .CNT_W            (32)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .no_forwarding_data_IDR  (idr),
        .no_forwarding_data_EXB  (exb),
        .no_forwarding_data_MEMP (memp),
        .redirect_EXA            (redirect),
        .redirect_pc_EXA         (rpc),
        .dm_req_MEMP             (req),
        .dm_ack                  (ack),
        .stage_en                (stage_en),
        .bubble                  (bubble),
        .pc_redirect_valid       (pcv),
        .pc_redirect             (pcr),
        .hazard_timeout          (timeout),
        .stall_cycles            (stall_cycles),
        .flush_count             (flush_count)
    );

    // Apply one cycle of inputs at the falling edge and let outputs settle.
    task automatic drive(input logic i_idr, input logic i_exb, input logic i_memp,
                         input logic i_red, input logic [63:0] i_pc,
                         input logic i_req, input logic i_ack);
        @(negedge clk);
        idr = i_idr; exb = i_exb; memp = i_memp;
        redirect = i_red; rpc = i_pc; req = i_req; ack = i_ack;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 64'h0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        n_cmp++;
        if ({stage_en, bubble, pcv} !== {8'h00, 8'hFF, 1'b0} || pcr !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got en=%h bub=%h pcv=%b pc=%h exp en=00 bub=FF pcv=0 pc=0",
                     stage_en, bubble, pcv, pcr);
        end
        n_cmp++;
        if ({stall_cycles, flush_count, timeout} !== 65'h0) begin
            n_bad++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d to=%b exp 0 0 0",
                     stall_cycles, flush_count, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_cmp++;
        if ({stage_en, bubble} !== {8'hFF, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_release: got en=%h bub=%h exp en=FF bub=00", stage_en, bubble);
        end
    endtask

    task automatic test_idr_hazard();
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 0, 64'h0, 0, 0);
            n_cmp++;
            if ({stage_en, bubble} !== {8'hFC, 8'h04}) begin
                n_bad++;
                $display("FAIL idr_stall c%0d: got en=%h bub=%h exp en=FC bub=04", c, stage_en, bubble);
            end
        end
        idle();
        n_cmp++;
        if ({stage_en, bubble} !== {8'hFF, 8'h00} || stall_cycles !== 32'd3) begin
            n_bad++;
            $display("FAIL idr_release: got en=%h bub=%h stall=%0d exp en=FF bub=00 stall=3",
                     stage_en, bubble, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 1, 64'h8000_0100, 1, 0);
            n_cmp++;
            if ({stage_en, bubble, pcv} !== {8'hC0, 8'h40, 1'b0}) begin
                n_bad++;
                $display("FAIL mem_wait c%0d: got en=%h bub=%h pcv=%b exp en=C0 bub=40 pcv=0",
                         c, stage_en, bubble, pcv);
            end
        end
        drive(0, 0, 0, 1, 64'h8000_0100, 1, 1);
        n_cmp++;
        if ({stage_en, bubble, pcv} !== {8'hFF, 8'h1E, 1'b1} || pcr !== 64'h8000_0100) begin
            n_bad++;
            $display("FAIL mem_ack_redir: got en=%h bub=%h pcv=%b pc=%h exp en=FF bub=1E pcv=1 pc=80000100",
                     stage_en, bubble, pcv, pcr);
        end
        idle();
        n_cmp++;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd7 || bubble !== 8'h02) begin
            n_bad++;
            $display("FAIL mem_after: got flush=%0d stall=%0d bub=%h exp flush=1 stall=7 bub=02",
                     flush_count, stall_cycles, bubble);
        end
        idle();
        idle();
    endtask

    task automatic test_refill();
        drive(0, 0, 0, 1, 64'h8000_0040, 0, 0);
        n_cmp++;
        if ({pcv, bubble} !== {1'b1, 8'h1E} || pcr !== 64'h8000_0040) begin
            n_bad++;
            $display("FAIL refill_redir: got pcv=%b bub=%h pc=%h exp pcv=1 bub=1E pc=80000040",
                     pcv, bubble, pcr);
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 0, 0, 64'h0, 0, 0);
            n_cmp++;
            if ({stage_en, bubble, pcv} !== {8'hFF, 8'h02, 1'b0}) begin
                n_bad++;
                $display("FAIL refill_bub c%0d: got en=%h bub=%h pcv=%b exp en=FF bub=02 pcv=0",
                         c, stage_en, bubble, pcv);
            end
        end
        drive(0, 1, 0, 0, 64'h0, 0, 0);
        n_cmp++;
        if ({stage_en, bubble} !== {8'hFC, 8'h04}) begin
            n_bad++;
            $display("FAIL refill_to_run: got en=%h bub=%h exp en=FC bub=04", stage_en, bubble);
        end
        idle();
        n_cmp++;
        if (flush_count !== 32'd2 || stall_cycles !== 32'd8) begin
            n_bad++;
            $display("FAIL refill_cnt: got flush=%0d stall=%0d exp flush=2 stall=8", flush_count, stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 1, 64'h0000_1000, 0, 0);
        drive(0, 0, 0, 1, 64'h0000_2000, 0, 0);
        n_cmp++;
        if ({pcv, bubble} !== {1'b1, 8'h1E} || pcr !== 64'h0000_2000) begin
            n_bad++;
            $display("FAIL b2b_second: got pcv=%b bub=%h pc=%h exp pcv=1 bub=1E pc=2000", pcv, bubble, pcr);
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 0, 0, 64'h0, 0, 0);
            n_cmp++;
            if ({stage_en, bubble} !== {8'hFF, 8'h02}) begin
                n_bad++;
                $display("FAIL b2b_reload c%0d: got en=%h bub=%h exp en=FF bub=02", c, stage_en, bubble);
            end
        end
        drive(0, 1, 0, 0, 64'h0, 0, 0);
        n_cmp++;
        if ({stage_en, bubble, flush_count} !== {8'hFC, 8'h04, 32'd4}) begin
            n_bad++;
            $display("FAIL b2b_end: got en=%h bub=%h flush=%0d exp en=FC bub=04 flush=4",
                     stage_en, bubble, flush_count);
        end
        idle();
    endtask

    task automatic test_mstall_in_refill();
        drive(0, 0, 0, 1, 64'h0000_3000, 0, 0);
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 64'h0, 1, 0);
            n_cmp++;
            if ({stage_en, bubble} !== {8'hC0, 8'h40}) begin
                n_bad++;
                $display("FAIL refill_mstall c%0d: got en=%h bub=%h exp en=C0 bub=40", c, stage_en, bubble);
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 0, 0, 64'h0, 0, 0);
            n_cmp++;
            if ({stage_en, bubble} !== {8'hFF, 8'h02}) begin
                n_bad++;
                $display("FAIL refill_hold c%0d: got en=%h bub=%h exp en=FF bub=02", c, stage_en, bubble);
            end
        end
        drive(0, 1, 0, 0, 64'h0, 0, 0);
        n_cmp++;
        if ({stage_en, bubble} !== {8'hFC, 8'h04}) begin
            n_bad++;
            $display("FAIL refill_hold_end: got en=%h bub=%h exp en=FC bub=04", stage_en, bubble);
        end
        idle();
    endtask

    task automatic test_watchdog();
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 1, 0, 64'h0, 0, 0);
            n_cmp++;
            if (timeout !== (c == 8)) begin
                n_bad++;
                $display("FAIL wdog c%0d: got to=%b exp %b", c, timeout, (c == 8));
            end
        end
        idle();
        idle();
        n_cmp++;
        if (timeout !== 1'b1 || stall_cycles !== 32'd20) begin
            n_bad++;
            $display("FAIL wdog_sticky: got to=%b stall=%0d exp to=1 stall=20", timeout, stall_cycles);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({timeout, stall_cycles, flush_count} !== 65'h0) begin
            n_bad++;
            $display("FAIL wdog_rst: got to=%b stall=%0d flush=%0d exp 0 0 0", timeout, stall_cycles, flush_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        drive(0, 0, 0, 1, 64'h0000_4000, 0, 0);
        drive(0, 0, 0, 0, 64'h0, 0, 0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({stage_en, bubble} !== {8'h00, 8'hFF}) begin
            n_bad++;
            $display("FAIL rst_mid: got en=%h bub=%h exp en=00 bub=FF", stage_en, bubble);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, 0, 64'h0, 0, 0);
        n_cmp++;
        if ({stage_en, bubble} !== {8'hFC, 8'h04}) begin
            n_bad++;
            $display("FAIL rst_mid_run: got en=%h bub=%h exp en=FC bub=04", stage_en, bubble);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idr = 0; exb = 0; memp = 0; redirect = 0; rpc = '0; req = 0; ack = 0;
        test_reset();
        test_idr_hazard();
        test_mem_wait();
        test_refill();
        test_back_to_back();
        test_mstall_in_refill();
        test_watchdog();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
